set_assoc_cache: RTL and testbench

SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

---
 rtl/set_assoc_cache.sv | 158 +++++++++++++++
 tb/tb_set_assoc_cache.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/set_assoc_cache.sv
// rtl/set_assoc_cache.sv - blocking set-associative write-back cache with round-robin replacement
// One outstanding miss: evict dirty victim, fill line, then replay the original access as a hit.
module set_assoc_cache #(
  parameter int WAYS       = 2,
  parameter int SETS       = 256,
  parameter int LINE_WORDS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rden,
  input  logic                     wren,
  input  logic [31:0]              addr_in,
  input  logic [31:0]              data_in,
  output logic                     interface_ready,
  output logic [31:0]              data_out,
  output logic                     data_out_valid,
  output logic [31:0]              mem_addr,
  output logic                     mem_rden,
  output logic                     mem_wren,
  output logic [32*LINE_WORDS-1:0] mem_wdata,
  input  logic [32*LINE_WORDS-1:0] mem_rdata,
  input  logic                     mem_rdata_valid
);
  localparam int OFS = $clog2(LINE_WORDS) + 2;
  localparam int IDX = $clog2(SETS);
  localparam int TAG = 32 - IDX - OFS;
  localparam int WW  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int WDW = $clog2(LINE_WORDS);
  localparam int LB  = 32 * LINE_WORDS;

  typedef enum logic [2:0] {IDLE, EVICT, FILL, WAIT, REPLAY} state_t;
  state_t state, next;

  logic [LB-1:0]   data_mem [SETS][WAYS];
  logic [TAG-1:0]  tag_mem  [SETS][WAYS];
  logic [WAYS-1:0] valid    [SETS];
  logic [WAYS-1:0] dirty    [SETS];
  logic [WW-1:0]   rr       [SETS];

  logic [TAG-1:0] tag_in, l_tag;
  logic [IDX-1:0] idx_in, l_idx, acc_idx;
  logic [WDW-1:0] word_in, l_word, acc_word;
  logic [31:0]    l_data, acc_data;
  logic           l_wr, acc_wr;
  logic [WW-1:0]  l_way, acc_way, hit_way, vic_way;
  logic           req, hit, have_inv, miss, do_acc, fill_done;
  logic           unused_addr;

  assign tag_in      = addr_in[31 -: TAG];
  assign idx_in      = addr_in[OFS +: IDX];
  assign word_in     = addr_in[2 +: WDW];
  assign unused_addr = ^addr_in[1:0];
  assign req         = rden | wren;

  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    have_inv = 1'b0;
    vic_way  = rr[idx_in];
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid[idx_in][w] && tag_mem[idx_in][w] == tag_in) begin
        hit     = 1'b1;
        hit_way = w[WW-1:0];
      end
      if (!have_inv && !valid[idx_in][w]) begin
        have_inv = 1'b1;
        vic_way  = w[WW-1:0];
      end
    end
  end

  assign miss      = (state == IDLE) && req && !hit;
  assign do_acc    = ((state == IDLE) && req && hit) || (state == REPLAY);
  assign fill_done = (state == WAIT) && mem_rdata_valid;

  // Hits are served straight from the inputs; a replay uses the latched miss request.
  always_comb begin
    if (state == REPLAY) begin
      acc_idx = l_idx; acc_way = l_way; acc_word = l_word; acc_wr = l_wr; acc_data = l_data;
    end else begin
      acc_idx = idx_in; acc_way = hit_way; acc_word = word_in; acc_wr = wren; acc_data = data_in;
    end
  end

  always_comb begin
    next            = state;
    interface_ready = 1'b0;
    mem_rden        = 1'b0;
    mem_wren        = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    case (state)
      IDLE: begin
        interface_ready = !miss;
        if (miss) next = EVICT;
      end
      EVICT: begin
        if (valid[l_idx][l_way] && dirty[l_idx][l_way]) begin
          mem_wren  = 1'b1;
          mem_addr  = {tag_mem[l_idx][l_way], l_idx, {OFS{1'b0}}};
          mem_wdata = data_mem[l_idx][l_way];
        end
        next = FILL;
      end
      FILL: begin
        mem_rden = 1'b1;
        mem_addr = {l_tag, l_idx, {OFS{1'b0}}};
        next     = WAIT;
      end
      WAIT:    if (mem_rdata_valid) next = REPLAY;
      REPLAY:  next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      l_tag <= '0; l_idx <= '0; l_word <= '0; l_data <= '0; l_wr <= 1'b0; l_way <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
        rr[s]    <= '0;
      end
    end else begin
      state          <= next;
      data_out_valid <= 1'b0;
      if (miss) begin
        l_tag <= tag_in; l_idx <= idx_in; l_word <= word_in;
        l_data <= data_in; l_wr <= wren; l_way <= vic_way;
        // The pointer only advances when it actually picked the victim.
        if (!have_inv && WAYS > 1) rr[idx_in] <= rr[idx_in] + 1'b1;
      end
      if (fill_done) begin
        valid[l_idx][l_way] <= 1'b1;
        dirty[l_idx][l_way] <= 1'b0;
      end
      if (do_acc) begin
        if (acc_wr) begin
          dirty[acc_idx][acc_way] <= 1'b1;
        end else begin
          data_out_valid <= 1'b1;
          data_out       <= data_mem[acc_idx][acc_way][{acc_word, 5'b0} +: 32];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_done) begin
      data_mem[l_idx][l_way] <= mem_rdata;
      tag_mem[l_idx][l_way]  <= l_tag;
    end
    if (do_acc && acc_wr) data_mem[acc_idx][acc_way][{acc_word, 5'b0} +: 32] <= acc_data;
  end
endmodule

// File: tb/tb_set_assoc_cache.sv
// tb/tb_set_assoc_cache.sv - scoreboard bench for set_assoc_cache with default parameters
// Memory returns word w of line A as 0xA000_0000 | (A + 4*w).
module tb_set_assoc_cache;
  logic         clk = 1'b0;
  logic         reset, rden, wren;
  logic [31:0]  addr_in, data_in;
  logic         interface_ready, data_out_valid, mem_rden, mem_wren;
  logic [31:0]  data_out, mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_rdata_valid;

  set_assoc_cache dut (
    .clk(clk), .reset(reset), .rden(rden), .wren(wren), .addr_in(addr_in), .data_in(data_in),
    .interface_ready(interface_ready), .data_out(data_out), .data_out_valid(data_out_valid),
    .mem_addr(mem_addr), .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] d; int c; } dexp_t;
  typedef struct { logic wr; logic [31:0] a; logic [127:0] wd; int c; } mexp_t;
  dexp_t dq[$];
  mexp_t mq[$];

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    dexp_t de;
    mexp_t me;
    if (!reset) begin
      if (data_out_valid) begin
        if (dq.size() == 0) chk("unexpected data_out_valid", 1, 0);
        else begin
          de = dq.pop_front();
          chk("data_out", data_out, de.d);
          chk("data_out cycle", cyc, de.c);
        end
      end
      if (mem_rden && mem_wren) chk("rden and wren together", 1, 0);
      if (mem_rden || mem_wren) begin
        if (mq.size() == 0) chk("unexpected mem op", {mem_wren, mem_addr}, 0);
        else begin
          me = mq.pop_front();
          chk("mem op is write", mem_wren, me.wr);
          chk("mem_addr", mem_addr, me.a);
          chk("mem op cycle", cyc, me.c);
          if (me.wr) chk("mem_wdata", mem_wdata, me.wd);
        end
      end
    end
  end

  int          mem_lat = 5;
  int          pend = 0;
  logic [31:0] pend_addr;

  always @(negedge clk) if (mem_rden) begin pend = mem_lat; pend_addr = mem_addr; end

  initial begin
    mem_rdata_valid = 1'b0;
    mem_rdata       = '0;
    forever begin
      @(posedge clk); #1;
      mem_rdata_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mem_rdata_valid = 1'b1;
          for (int w = 0; w < 4; w++) mem_rdata[w*32 +: 32] = 32'hA000_0000 | (pend_addr + 32'(4*w));
        end
      end
    end
  end

  // Called just after a rising edge; returns once the cache is idle again.
  task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic miss, input logic [31:0] expd,
                        input logic ev, input logic [31:0] ev_addr, input logic [127:0] ev_wd);
    int k, n;
    mexp_t m;
    dexp_t x;
    k = cyc;
    if (miss) begin
      if (ev) begin m.wr = 1'b1; m.a = ev_addr; m.wd = ev_wd; m.c = k + 1; mq.push_back(m); end
      m.wr = 1'b0; m.a = a & 32'hFFFF_FFF0; m.wd = '0; m.c = k + 2; mq.push_back(m);
    end
    if (!wr) begin x.d = expd; x.c = miss ? k + mem_lat + 4 : k + 1; dq.push_back(x); end
    rden = !wr; wren = wr; addr_in = a; data_in = d;
    #1 chk("interface_ready on request", interface_ready, !miss);
    @(posedge clk); #1;
    rden = 1'b0; wren = 1'b0;
    n = 0;
    while (!interface_ready && n < 60) begin @(posedge clk); #1; n++; end
    chk("return to idle", interface_ready, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; rden = 1'b0; wren = 1'b0; addr_in = '0; data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset interface_ready", interface_ready, 1);
    chk("reset data_out", data_out, 0);
    chk("reset data_out_valid", data_out_valid, 0);
    chk("reset mem_rden", mem_rden, 0);
    chk("reset mem_wren", mem_wren, 0);
    chk("reset mem_addr", mem_addr, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    access(0, 32'h40,   0, 1, 32'hA000_0040, 0, 0, 0);
    access(1, 32'h44,   32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    access(0, 32'h44,   0, 0, 32'hDEAD_BEEF, 0, 0, 0);
    access(0, 32'h4040, 0, 1, 32'hA000_4040, 0, 0, 0);
    access(0, 32'h40,   0, 0, 32'hA000_0040, 0, 0, 0);
    access(0, 32'h4040, 0, 0, 32'hA000_4040, 0, 0, 0);
    access(0, 32'hC044, 0, 1, 32'hA000_C044, 1, 32'h40,
           {32'hA000_004C, 32'hA000_0048, 32'hDEAD_BEEF, 32'hA000_0040});
    access(0, 32'h4044, 0, 0, 32'hA000_4044, 0, 0, 0);
    access(0, 32'h40,   0, 1, 32'hA000_0040, 0, 0, 0);
    access(1, 32'h80,   32'h1234_5678, 1, 0, 0, 0, 0);
    access(0, 32'h80,   0, 0, 32'h1234_5678, 0, 0, 0);
    access(0, 32'h4080, 0, 1, 32'hA000_4080, 0, 0, 0);
    access(0, 32'h8084, 0, 1, 32'hA000_8084, 1, 32'h80,
           {32'hA000_008C, 32'hA000_0088, 32'hA000_0084, 32'h1234_5678});

    begin : reset_mid_miss
      mexp_t m;
      mem_lat = 8;
      m.wr = 1'b0; m.a = 32'h100; m.wd = '0; m.c = cyc + 2; mq.push_back(m);
      rden = 1'b1; addr_in = 32'h100;
      @(posedge clk); #1;
      rden = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("interface_ready after mid-miss reset", interface_ready, 1);
      repeat (10) @(posedge clk);
      #1;
      chk("interface_ready after stray fill", interface_ready, 1);
      mem_lat = 5;
    end
    access(0, 32'h100, 0, 1, 32'hA000_0100, 0, 0, 0);

    repeat (10) @(posedge clk);
    chk("outstanding data expectations", dq.size(), 0);
    chk("outstanding mem expectations", mq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
